// File: rtl/element_defs.sv
// Shared definitions for the Element arithmetic blocks: operand width,
// iteration counter width and the sequential divider state encoding.
package element_defs;
    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ADC32.sv
// 32-bit add with carry-in and carry-out: {Co, S} = A + B + C0.
// Latency: combinational. Backpressure: none.
// Used by the divider as a subtractor (B = ~divisor, C0 = 1).
module ADC32
    import element_defs::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic [WIDTH-1:0] S,
    output logic             Co
);
    assign {Co, S} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C0};
endmodule

// File: rtl/div32_seq.sv
// Sequential unsigned 32-bit restoring divider, one quotient bit per clock.
// Latency: 32 edges from accept to done (divide-by-zero: done on the next cycle).
// Backpressure: start is only honoured in IDLE/DONE; requests during RUN are dropped.
module div32_seq
    import element_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_reg, r_reg, d_reg;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     s;
    logic [WIDTH-1:0]   diff;
    logic               co;
    logic               ge;
    logic [WIDTH-1:0]   q_next, r_next;
    logic               accept;

    // Shift in the next dividend bit and try subtracting the divisor.
    assign s = {r_reg, q_reg[WIDTH-1]};

    ADC32 u_adc (
        .A  (s[WIDTH-1:0]),
        .B  (~d_reg),
        .C0 (1'b1),
        .S  (diff),
        .Co (co)
    );

    // s[32] set means the shifted remainder already exceeds any 32-bit divisor.
    assign ge     = s[WIDTH] | co;
    assign r_next = ge ? diff : s[WIDTH-1:0];
    assign q_next = {q_reg[WIDTH-2:0], ge};
    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (divisor != '0) ? RUN : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (divisor != '0) begin
                    q_reg <= dividend;
                    r_reg <= '0;
                    d_reg <= divisor;
                    cnt   <= CNT_W'(WIDTH - 1);
                end else begin
                    quotient  <= '1;
                    remainder <= dividend;
                    div_zero  <= 1'b1;
                end
            end else if (state_q == RUN) begin
                q_reg <= q_next;
                r_reg <= r_next;
                cnt   <= cnt - 1'b1;
                if (cnt == '0) begin
                    quotient  <= q_next;
                    remainder <= r_next;
                    div_zero  <= 1'b0;
                end
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_div32_seq.sv
// Directed and randomised checks of div32_seq against plain integer division.
module tb_div32_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; the request is accepted on the next rising edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // k = rising edges after the reference edge until done is seen; nb = busy cycles.
    task automatic wait_done(output int k, output int nb);
        k  = 0;
        nb = 0;
        @(negedge clk);
        while (!done && k < 40) begin
            if (busy) nb++;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    // Reference: plain integer division, with the all-ones/dividend convention for zero.
    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        ez;
        if (b == 0) begin
            eq = 32'hFFFF_FFFF; er = a; ez = 1'b1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0;
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " quotient"}, quotient, 32'd0);
        check({tag, " remainder"}, remainder, 32'd0);
        check({tag, " div_zero"}, {31'd0, div_zero}, 32'd0);
    endtask

    initial begin
        int k, nb, seen;
        logic [31:0] a, b;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // 100 / 7: latency and busy width
        start_op(32'd100, 32'd7);
        wait_done(k, nb);
        check("100/7 latency", k, 32'd32);
        check("100/7 busy_cycles", nb, 32'd32);
        check_result("100/7", 32'd100, 32'd7);
        @(negedge clk);
        check("100/7 done_drops", {31'd0, done}, 32'd0);
        check("100/7 idle_busy", {31'd0, busy}, 32'd0);

        start_op(32'hFFFF_FFFF, 32'd1);
        wait_done(k, nb);
        check_result("max/1", 32'hFFFF_FFFF, 32'd1);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(k, nb);
        check_result("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start_op(32'd3, 32'd5);
        wait_done(k, nb);
        check_result("3/5", 32'd3, 32'd5);

        // divide by zero: done straight after the accepting edge, no busy
        @(negedge clk);
        start_op(32'd5, 32'd0);
        wait_done(k, nb);
        check("5/0 latency", k, 32'd0);
        check("5/0 busy_cycles", nb, 32'd0);
        check_result("5/0", 32'd5, 32'd0);

        // start during RUN is ignored
        @(negedge clk);
        start_op(32'd1000, 32'd33);
        repeat (10) @(negedge clk);
        start_op(32'd9, 32'd2);
        wait_done(k, nb);
        check("ignored latency", k, 32'd22);
        check_result("1000/33", 32'd1000, 32'd33);

        // back-to-back: accepted during the done cycle
        start_op(32'd9, 32'd2);
        @(negedge clk);
        check("b2b done_drops", {31'd0, done}, 32'd0);
        check("b2b busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        wait_done(k, nb);
        check("b2b latency", k, 32'd31);
        check_result("9/2", 32'd9, 32'd2);

        // reset mid-run: everything clears, no done ever appears
        @(negedge clk);
        start_op(32'd2349, 32'd234);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrun_rst");
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("midrun_rst no_done", seen, 32'd0);
        start_op(32'd2349, 32'd234);
        wait_done(k, nb);
        check_result("2349/234", 32'd2349, 32'd234);

        // rst and start on the same edge: rst wins
        @(negedge clk);
        dividend = 32'd7; divisor = 32'd1; start = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; rst = 1'b0; end
        @(negedge clk);
        check_idle_outputs("rst_vs_start");

        for (int i = 0; i < 500; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = $urandom_range(255, 1);
            if (i % 4 == 1) b = b >> $urandom_range(31, 0);
            if (i % 50 == 0) a = 32'd0;
            if (b == 0) b = 32'd1;
            start_op(a, b);
            wait_done(k, nb);
            check("rand latency", k, 32'd32);
            check_result("rand", a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
